bcd_formatter_seq: RTL and testbench

- Sequential binary-to-BCD converter using the shift-add-3 (double-dabble) method, one bit per clock.
- Sits directly upstream of the 7-segment scan driver and feeds it decimal digits for cycle counts and input counts, replacing raw hex display.
- Produces packed BCD digits, a leading-zero blank mask and an overflow flag, with a start/busy/done handshake.

---
 rtl/bcd_formatter_seq_pkg.sv | 24 ++
 rtl/bcd_add3.sv | 18 +
 rtl/bcd_formatter_seq.sv | 148 ++++++++++++++
 tb/tb_bcd_formatter_seq.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/bcd_formatter_seq_pkg.sv
// Shared display definitions: digit width, display size, digit type, blank
// code understood by the scan driver, converter FSM states and sizing helper.
package bcd_formatter_seq_pkg;

   localparam int BCD_W       = 4;
   localparam int DISP_DIGITS = 8;

   typedef logic [BCD_W-1:0] bcd_digit_t;

   // Digit code the scan driver renders as an unlit position.
   localparam bcd_digit_t BLANK_CODE = 4'hF;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } conv_state_e;

   // Decimal digits needed to hold any bw-bit unsigned value:
   // ceil(bw * log10(2)), with log10(2) approximated as 0.30103.
   function automatic int wk_digits(input int bw);
      return (bw * 30103 + 99999) / 100000;
   endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets 3 added so
// the following left shift carries correctly into the next decimal digit.
module bcd_add3
   import bcd_formatter_seq_pkg::*;
(
   input  bcd_digit_t digit_i,
   output bcd_digit_t digit_o
);

   // Conditional +3 on digits 5..9 (larger codes never occur in practice).
   always_comb begin
      digit_o = digit_i;
      if (digit_i >= 4'd5) begin
         digit_o = digit_i + 4'd3;
      end
   end

endmodule

// File: rtl/bcd_formatter_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock)
// feeding the 7-segment scan driver with packed digits, a leading-zero
// blank mask and an overflow flag, behind a start/busy/done handshake.
module bcd_formatter_seq
   import bcd_formatter_seq_pkg::*;
#(
   parameter int BIN_W  = 32,
   parameter int DIGITS = DISP_DIGITS
)
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [BIN_W-1:0]          bin_in,
   output logic                      busy,
   output logic                      done,
   output logic [BCD_W*DIGITS-1:0]   bcd_out,
   output logic [DIGITS-1:0]         blank_mask,
   output logic                      ovf
);

   // Working register is wide enough that no input value ever truncates.
   localparam int WK_DIGITS = wk_digits(BIN_W);
   localparam int WK_W      = BCD_W * WK_DIGITS;
   localparam int OUT_W     = BCD_W * DIGITS;
   localparam int EXT_W     = (WK_W > OUT_W) ? WK_W : OUT_W;
   localparam int CNT_W     = $clog2(BIN_W + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

   conv_state_e         state_q, state_d;
   logic [BIN_W-1:0]    sr_q, sr_d;
   logic [WK_W-1:0]     wk_q, wk_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [OUT_W-1:0]    bcd_q, bcd_d;
   logic [DIGITS-1:0]   blank_q, blank_d;
   logic                ovf_q, ovf_d;
   logic                done_q, done_d;

   logic [WK_W-1:0]     wk_adj;
   logic [WK_W-1:0]     wk_shift;
   logic [EXT_W-1:0]    wk_ext;
   logic [OUT_W-1:0]    fin_bcd;
   logic [DIGITS-1:0]   fin_blank;
   logic                fin_ovf;

   // One add-3 cell per working digit, all corrected in parallel.
   genvar gi;
   generate
      for (gi = 0; gi < WK_DIGITS; gi++) begin : g_add3
         bcd_add3 u_add3 (
            .digit_i (wk_q[BCD_W*gi +: BCD_W]),
            .digit_o (wk_adj[BCD_W*gi +: BCD_W])
         );
      end
   endgenerate

   // Shift the corrected digits left, pulling in the next binary MSB.
   assign wk_shift = {wk_adj[WK_W-2:0], sr_q[BIN_W-1]};
   assign wk_ext   = EXT_W'(wk_shift);

   // Final formatting of the value completing on this edge: saturate on
   // overflow, otherwise take the low digits and blank leading zeros.
   always_comb begin
      logic higher_zero;
      fin_ovf     = |(wk_ext >> OUT_W);
      fin_bcd     = wk_ext[OUT_W-1:0];
      fin_blank   = '0;
      higher_zero = 1'b1;
      if (fin_ovf) begin
         fin_bcd = {DIGITS{4'h9}};
      end else begin
         for (int i = DIGITS - 1; i >= 1; i--) begin
            if (fin_bcd[BCD_W*i +: BCD_W] != '0) begin
               higher_zero = 1'b0;
            end
            fin_blank[i] = higher_zero;
         end
      end
   end

   // Next-state logic: accept a start in IDLE, run BIN_W shift steps,
   // publish the formatted result on the last step.
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      wk_d    = wk_q;
      cnt_d   = cnt_q;
      bcd_d   = bcd_q;
      blank_d = blank_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               sr_d    = bin_in;
               wk_d    = '0;
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            sr_d  = {sr_q[BIN_W-2:0], 1'b0};
            wk_d  = wk_shift;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
               state_d = ST_IDLE;
               bcd_d   = fin_bcd;
               blank_d = fin_blank;
               ovf_d   = fin_ovf;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and result registers; reset discards any conversion in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sr_q    <= '0;
         wk_q    <= '0;
         cnt_q   <= '0;
         bcd_q   <= '0;
         blank_q <= '0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         wk_q    <= wk_d;
         cnt_q   <= cnt_d;
         bcd_q   <= bcd_d;
         blank_q <= blank_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end

   assign busy       = (state_q == ST_SHIFT);
   assign done       = done_q;
   assign bcd_out    = bcd_q;
   assign blank_mask = blank_q;
   assign ovf        = ovf_q;

endmodule

// File: tb/tb_bcd_formatter_seq.sv
// Directed bench for bcd_formatter_seq: reset, conversions, overflow,
// ignored starts while busy and reset in the middle of a conversion.
module tb_bcd_formatter_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] bin_in;
   logic        busy;
   logic        done;
   logic [31:0] bcd_out;
   logic [7:0]  blank_mask;
   logic        ovf;

   int total = 0;
   int bad   = 0;

   bcd_formatter_seq #(.BIN_W(32), .DIGITS(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .bin_in     (bin_in),
      .busy       (busy),
      .done       (done),
      .bcd_out    (bcd_out),
      .blank_mask (blank_mask),
      .ovf        (ovf)
   );

   always #5 clk = ~clk;

   // Start a conversion and follow it to done (bounded). lat is the number
   // of edges from the accepting edge to the one that raised done.
   task automatic run_conv(input logic [31:0] val, output int lat,
                           output int busy_cyc);
      lat      = -1;
      busy_cyc = 0;
      @(negedge clk);
      start  = 1'b1;
      bin_in = val;
      @(posedge clk);
      #1;
      start  = 1'b0;
      bin_in = 32'hDEAD_BEEF;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (done) begin
            lat = k;
            break;
         end
         if (busy) busy_cyc++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; bin_in = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
      total++; if (bcd_out !== 32'h0) begin bad++; $display("FAIL reset_bcd got=%h exp=00000000", bcd_out); end
      total++; if (blank_mask !== 8'h00) begin bad++; $display("FAIL reset_blank got=%h exp=00", blank_mask); end
      total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
      $display("reset: busy=%b done=%b bcd=%h blank=%h ovf=%b", busy, done, bcd_out, blank_mask, ovf);
   endtask

   task automatic test_conv(input string nm, input logic [31:0] val,
                            input logic [31:0] exp_bcd, input logic [7:0] exp_blank,
                            input logic exp_ovf);
      int lat, bc;
      run_conv(val, lat, bc);
      total++; if (lat !== 32) begin bad++; $display("FAIL %s_latency got=%0d exp=32", nm, lat); end
      total++; if (bc !== 32) begin bad++; $display("FAIL %s_busy_cycles got=%0d exp=32", nm, bc); end
      total++; if (bcd_out !== exp_bcd) begin bad++; $display("FAIL %s_bcd got=%h exp=%h", nm, bcd_out, exp_bcd); end
      total++; if (blank_mask !== exp_blank) begin bad++; $display("FAIL %s_blank got=%h exp=%h", nm, blank_mask, exp_blank); end
      total++; if (ovf !== exp_ovf) begin bad++; $display("FAIL %s_ovf got=%b exp=%b", nm, ovf, exp_ovf); end
      @(negedge clk);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL %s_done_width got=%b exp=0", nm, done); end
      $display("%s: in=%0d lat=%0d bcd=%h blank=%h ovf=%b", nm, val, lat, bcd_out, blank_mask, ovf);
   endtask

   task automatic test_ignore_start();
      int  first_done = -1;
      int  second_done = -1;
      logic [31:0] first_bcd = '0;
      logic [7:0]  first_blank = '0;
      @(negedge clk);
      start = 1'b1; bin_in = 32'd42;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (done) begin
            if (first_done < 0) begin
               first_done  = k;
               first_bcd   = bcd_out;
               first_blank = blank_mask;
            end else if (second_done < 0) begin
               second_done = k;
            end
         end
         if (k == 4 || k == 31) begin start = 1'b1; bin_in = 32'd99; end
         else if (k == 5 || k == 33) begin start = 1'b0; bin_in = 32'd99; end
         else if (k == 32) begin start = 1'b1; bin_in = 32'd7; end
         if (second_done >= 0) break;
      end
      total++; if (first_done !== 32) begin bad++; $display("FAIL ignore_first_latency got=%0d exp=32", first_done); end
      total++; if (first_bcd !== 32'h0000_0042) begin bad++; $display("FAIL ignore_first_bcd got=%h exp=00000042", first_bcd); end
      total++; if (first_blank !== 8'hFC) begin bad++; $display("FAIL ignore_first_blank got=%h exp=fc", first_blank); end
      total++; if (second_done !== 65) begin bad++; $display("FAIL done_cycle_start_latency got=%0d exp=65", second_done); end
      total++; if (bcd_out !== 32'h0000_0007) begin bad++; $display("FAIL done_cycle_start_bcd got=%h exp=00000007", bcd_out); end
      $display("ignore: first=%0d bcd=%h second=%0d bcd=%h", first_done, first_bcd, second_done, bcd_out);
   endtask

   task automatic test_reset_mid();
      int seen_done = 0;
      int lat, bc;
      @(negedge clk);
      start = 1'b1; bin_in = 32'd12345678;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (done) seen_done++;
         if (k == 9) rst = 1'b1;
         if (k == 10) begin
            rst = 1'b0;
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
            total++; if (bcd_out !== 32'h0) begin bad++; $display("FAIL midrst_bcd got=%h exp=00000000", bcd_out); end
            total++; if (blank_mask !== 8'h00) begin bad++; $display("FAIL midrst_blank got=%h exp=00", blank_mask); end
         end
      end
      total++; if (seen_done !== 0) begin bad++; $display("FAIL midrst_done_pulses got=%0d exp=0", seen_done); end
      run_conv(32'd9, lat, bc);
      total++; if (lat !== 32) begin bad++; $display("FAIL after_rst_latency got=%0d exp=32", lat); end
      total++; if (bcd_out !== 32'h0000_0009) begin bad++; $display("FAIL after_rst_bcd got=%h exp=00000009", bcd_out); end
      total++; if (blank_mask !== 8'hFE) begin bad++; $display("FAIL after_rst_blank got=%h exp=fe", blank_mask); end
      $display("reset_mid: done_pulses=%0d then in=9 lat=%0d bcd=%h", seen_done, lat, bcd_out);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; bin_in = '0;
      test_reset();
      test_conv("zero",  32'd0,         32'h0000_0000, 8'hFE, 1'b0);
      test_conv("mid",   32'd12345678,  32'h1234_5678, 8'h00, 1'b0);
      test_conv("b255",  32'd255,       32'h0000_0255, 8'hF8, 1'b0);
      test_conv("max8",  32'd99999999,  32'h9999_9999, 8'h00, 1'b0);
      test_conv("ovf1e8",32'd100000000, 32'h9999_9999, 8'h00, 1'b1);
      test_conv("ovfmax",32'hFFFF_FFFF, 32'h9999_9999, 8'h00, 1'b1);
      test_conv("b1000", 32'd1000,      32'h0000_1000, 8'hF0, 1'b0);
      test_ignore_start();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
